serial_subtractor: RTL and testbench

//  Multi-cycle N-bit subtractor with borrow: diff = a - b - Bin, Bout = borrow out.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared type for the bit-serial subtractor.
//   sub_state_t : controller state (IDLE, RUN, DONE)
// ----------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   Combinational 1-bit full subtractor: d = a - b - Bin, Bout = borrow out.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     Bin  in  1  borrow in
//     d    out 1  difference bit
//     Bout out 1  borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic Bin,
   output logic d,
   output logic Bout
);

   assign d    = a ^ b ^ Bin;
   // Borrow when b exceeds a outright, or when a == b and a borrow is pending.
   assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = a - b - Bin (mod 2^N), Bout = borrow.
//   One bit per clock, LSB first, through a single full_subtractor cell.
//   Start accepted at edge k -> busy for N cycles -> done pulse at cycle k+N+1.
//   Ports:
//     clk    in   1  rising-edge clock
//     rst_n  in   1  synchronous active-low reset (aborts any operation)
//     start  in   1  request, sampled only in IDLE or DONE
//     a      in   N  minuend, captured on accepted start
//     b      in   N  subtrahend, captured on accepted start
//     Bin    in   1  borrow in, captured on accepted start
//     busy   out  1  high while the operation is running
//     done   out  1  one-cycle pulse when diff/Bout become valid
//     diff   out  N  difference, held until next accepted start
//     Bout   out  1  final borrow out, held with diff
// ----------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         Bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         Bout
);

   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   sub_state_t    state;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [CW-1:0] cnt;
   logic          br;
   logic          d_bit;
   logic          br_next;

   // Operands are shifted right each RUN cycle so the current bit is always
   // at position 0; this avoids a variable bit-select on the counter.
   full_subtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .Bin  (br),
      .d    (d_bit),
      .Bout (br_next)
   );

   // Shift the new difference bit in at the MSB (works for N == 1 as well).
   function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur,
                                             input logic         msb);
      logic [N-1:0] t;
      t        = cur >> 1;
      t[N-1]   = msb;
      return t;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         Bout  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         cnt   <= '0;
         br    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= Bin;
                  cnt   <= '0;
                  diff  <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               diff <= shift_in(diff, d_bit);
               br   <= br_next;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  Bout  <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (N = 4). Expected results come
//   from plain integer arithmetic a - b - Bin.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int N   = 4;
   localparam int MOD = 2 ** N;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a     = '0;
   logic [N-1:0] b     = '0;
   logic         Bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         Bout;

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .Bout  (Bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer subtraction, wrapped to N bits, borrow = underflow.
   task automatic model(input int av, input int bv, input int bi,
                        output int dv, output int bo);
      int e;
      e  = av - bv - bi;
      bo = (e < 0) ? 1 : 0;
      dv = (e < 0) ? e + MOD : e;
   endtask

   // Entered at a negedge: present operands with start for one cycle.
   task automatic launch(input int av, input int bv, input int bi, input string tag);
      a     = N'(av);
      b     = N'(bv);
      Bin   = bi[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_on"}, 32'(busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(done), 32'd0);
   endtask

   // Wait for done (bounded), scrambling inputs meanwhile, then check result.
   // lat0 is the cycle index (relative to acceptance) the caller is at.
   task automatic finish_op(input int av, input int bv, input int bi,
                            input int lat0, input string tag);
      int lat;
      int bc;
      int dv;
      int bo;
      lat = lat0;
      bc  = lat0 - 1;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) bc++;
         a   = N'($urandom);
         b   = N'($urandom);
         Bin = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      model(av, bv, bi, dv, bo);
      chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(N));
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      chk({tag, "_diff"}, 32'(diff), 32'(dv));
      chk({tag, "_bout"}, 32'(Bout), 32'(bo));
   endtask

   task automatic run_op(input int av, input int bv, input int bi, input string tag);
      launch(av, bv, bi, tag);
      finish_op(av, bv, bi, 1, tag);
   endtask

   initial begin
      int pulses;
      int busy_seen;
      int gap;
      int ra;
      int rb;
      int rbi;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(Bout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // 1) 5 - 3 - 0
      run_op(5, 3, 0, "t1");
      @(negedge clk);
      chk("t1_pulse", 32'(done), 32'd0);

      // 2) 3 - 5 - 0 -> underflow
      run_op(3, 5, 0, "t2");
      @(negedge clk);
      chk("t2_pulse", 32'(done), 32'd0);

      // 3) 13 - 7 - 1, then 0 - 0 - 1 back-to-back from the DONE cycle
      run_op(13, 7, 1, "t3a");
      run_op(0, 0, 1, "t3b");
      repeat (3) @(negedge clk);
      chk("t3_hold_diff", 32'(diff), 32'hF);
      chk("t3_hold_bout", 32'(Bout), 32'd1);
      chk("t3_hold_done", 32'(done), 32'd0);

      // 4) start pulsed mid-RUN is ignored
      launch(2, 9, 0, "t4");
      @(negedge clk);
      a     = 4'd15;
      b     = 4'd1;
      Bin   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_op(2, 9, 0, 3, "t4");
      pulses    = 0;
      busy_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
         if (busy === 1'b1) busy_seen++;
      end
      chk("t4_extra_done", 32'(pulses), 32'd0);
      chk("t4_extra_busy", 32'(busy_seen), 32'd0);

      // 5) reset mid-RUN aborts the operation
      launch(12, 5, 1, "t5");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_diff", 32'(diff), 32'd0);
      chk("t5_bout", 32'(Bout), 32'd0);
      pulses    = 0;
      busy_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
         if (busy === 1'b1) busy_seen++;
      end
      chk("t5_no_done", 32'(pulses), 32'd0);
      chk("t5_no_busy", 32'(busy_seen), 32'd0);
      run_op(6, 11, 1, "t5_fresh");
      @(negedge clk);

      // 6) exhaustive sweep
      for (int ia = 0; ia < MOD; ia++) begin
         for (int ib = 0; ib < MOD; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               run_op(ia, ib, ic, "sweep");
               @(negedge clk);
               chk("sweep_once", 32'(done), 32'd0);
            end
         end
      end

      // Random operations with random gaps (gap 0 = back-to-back)
      for (int k = 0; k < 100; k++) begin
         ra  = int'($urandom_range(MOD - 1, 0));
         rb  = int'($urandom_range(MOD - 1, 0));
         rbi = int'($urandom_range(1, 0));
         run_op(ra, rb, rbi, "rand");
         gap = int'($urandom_range(2, 0));
         repeat (gap) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
